// File: rtl/boy_sprite_fetch_if.sv
// Sprite-ROM read bus: registered address out, palette index back one cycle later.
interface boy_sprite_fetch_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/boy_sprite_fetch.sv
// Fireboy per-pixel sprite fetch: animation frame select, mirrored ROM addressing,
// hit pipeline aligned with the ROM read, registered palette index and opaque flag.
module boy_sprite_fetch #(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int FRAMES      = 2,
  parameter int FRAME_TICKS = 8,
  parameter int ADDR_W      = 11,
  parameter int TRANSP_IDX  = 0
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  input  logic                frame_tick,
  input  logic                pix_en,
  input  logic [9:0]          draw_x,
  input  logic [9:0]          draw_y,
  input  logic [9:0]          boy_x,
  input  logic [9:0]          boy_y,
  input  logic                facing_left,
  input  logic                moving,
  boy_sprite_fetch_if.master  rom,
  output logic [3:0]          pal_index,
  output logic                boy_on
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  typedef enum logic {S_IDLE, S_WALK} anim_t;

  anim_t             state;
  logic [FW-1:0]     frame;
  logic [TW-1:0]     tick_cnt;
  logic              facing;

  logic [10:0]       dx, dy;
  logic              hit;
  logic [XW-1:0]     col;
  logic [ADDR_W-1:0] addr_next;
  logic              hit_d1, hit_d2;
  logic              opaque;

  // Animation and facing only move on frame_tick, so a frame never tears mid-scan.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      frame    <= '0;
      tick_cnt <= '0;
      facing   <= 1'b1;
    end else if (frame_tick) begin
      facing <= facing_left;
      case (state)
        S_IDLE: begin
          frame    <= '0;
          tick_cnt <= '0;
          if (moving) state <= S_WALK;
        end
        S_WALK: begin
          if (!moving) begin
            state    <= S_IDLE;
            frame    <= '0;
            tick_cnt <= '0;
          end else if (tick_cnt == TW'(FRAME_TICKS - 1)) begin
            tick_cnt <= '0;
            frame    <= (frame == FW'(FRAMES - 1)) ? '0 : frame + FW'(1);
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // 11-bit differences: a negative offset sets bit 10, so the box never wraps at 1023.
  always_comb begin
    dx  = {1'b0, draw_x} - {1'b0, boy_x};
    dy  = {1'b0, draw_y} - {1'b0, boy_y};
    hit = pix_en & ~dx[10] & (dx < 11'(SPR_W)) & ~dy[10] & (dy < 11'(SPR_H));
    col = facing ? dx[XW-1:0] : XW'(SPR_W - 1) - dx[XW-1:0];
    addr_next = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H)
              + ADDR_W'(dy[YW-1:0]) * ADDR_W'(SPR_W)
              + ADDR_W'(col);
    opaque = hit_d2 & (rom.rom_data != 4'(TRANSP_IDX));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom.rom_addr <= '0;
      hit_d1       <= 1'b0;
      hit_d2       <= 1'b0;
      boy_on       <= 1'b0;
      pal_index    <= '0;
    end else begin
      if (hit) rom.rom_addr <= addr_next;
      hit_d1    <= hit;
      hit_d2    <= hit_d1;
      boy_on    <= opaque;
      pal_index <= opaque ? rom.rom_data : '0;
    end
  end

endmodule

// File: tb/tb_boy_sprite_fetch.sv
// Directed bench for boy_sprite_fetch with a synchronous ROM model on the bus.
module tb_boy_sprite_fetch;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic       frame_tick;
  logic       pix_en;
  logic [9:0] draw_x, draw_y, boy_x, boy_y;
  logic       facing_left, moving;
  logic [3:0] pal_index;
  logic       boy_on;
  logic       force_transp;

  int checks = 0;
  int errors = 0;

  boy_sprite_fetch_if #(.ADDR_W(11)) bus ();

  boy_sprite_fetch #(
    .SPR_W(32), .SPR_H(32), .FRAMES(2), .FRAME_TICKS(8), .ADDR_W(11), .TRANSP_IDX(0)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick), .pix_en(pix_en),
    .draw_x(draw_x), .draw_y(draw_y), .boy_x(boy_x), .boy_y(boy_y),
    .facing_left(facing_left), .moving(moving), .rom(bus.master),
    .pal_index(pal_index), .boy_on(boy_on)
  );

  always #5 vga_clk = ~vga_clk;

  // ROM content: index = {addr[3:1],1}, never transparent unless forced.
  initial bus.rom_data = 4'h0;
  always @(posedge vga_clk)
    bus.rom_data <= force_transp ? 4'h0 : {bus.rom_addr[3:1], 1'b1};

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic en);
    draw_x = 10'(x);
    draw_y = 10'(y);
    pix_en = en;
  endtask

  task automatic ftick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; force_transp = 1'b0;
    facing_left = 1'b1; moving = 1'b0;
    boy_x = 10'd100; boy_y = 10'd50;
    pix(0, 0, 1'b0);
    step(); step();
    chk("rst_addr", 32'(bus.rom_addr), 0);
    chk("rst_on", 32'(boy_on), 0);
    chk("rst_pal", 32'(pal_index), 0);
    reset_n = 1'b1;
    step();

    // 1: facing left, frame 0, latency 3
    pix(100, 50, 1'b1); step();
    chk("t1_addr0", 32'(bus.rom_addr), 0);
    pix(107, 50, 1'b1); step();
    chk("t1_addr7", 32'(bus.rom_addr), 7);
    chk("t1_lat_early", 32'(boy_on), 0);
    pix(0, 0, 1'b0); step();
    chk("t1_on_a", 32'(boy_on), 1);
    chk("t1_pal_a", 32'(pal_index), 1);
    step();
    chk("t1_on_b", 32'(boy_on), 1);
    chk("t1_pal_b", 32'(pal_index), 7);
    step();
    chk("t1_off", 32'(boy_on), 0);
    chk("t1_pal_off", 32'(pal_index), 0);

    // 2: mirrored
    facing_left = 1'b0; ftick();
    pix(100, 50, 1'b1); step();
    chk("t2_addr31", 32'(bus.rom_addr), 31);
    pix(131, 81, 1'b1); step();
    chk("t2_addr992", 32'(bus.rom_addr), 992);
    pix(0, 0, 1'b0); step();
    chk("t2_pal_f", 32'(pal_index), 15);
    step();
    chk("t2_pal_1", 32'(pal_index), 1);

    // 3: walk animation
    facing_left = 1'b1; moving = 1'b1;
    ftick();
    for (int i = 0; i < 7; i++) ftick();
    pix(100, 50, 1'b1); frame_tick = 1'b1; step();
    chk("t3_pretick", 32'(bus.rom_addr), 0);
    frame_tick = 1'b0; step();
    chk("t3_frame1", 32'(bus.rom_addr), 1024);
    pix(0, 0, 1'b0);
    for (int i = 0; i < 7; i++) ftick();
    pix(100, 50, 1'b1); step(); pix(0, 0, 1'b0);
    chk("t3_still1", 32'(bus.rom_addr), 1024);
    ftick();
    pix(100, 50, 1'b1); step(); pix(0, 0, 1'b0);
    chk("t3_wrap0", 32'(bus.rom_addr), 0);
    for (int i = 0; i < 3; i++) ftick();
    moving = 1'b0; ftick();
    moving = 1'b1; ftick();
    for (int i = 0; i < 7; i++) ftick();
    pix(100, 50, 1'b1); step(); pix(0, 0, 1'b0);
    chk("t3_cnt_clr", 32'(bus.rom_addr), 0);
    ftick();
    pix(100, 50, 1'b1); step(); pix(0, 0, 1'b0);
    chk("t3_frame1b", 32'(bus.rom_addr), 1024);
    moving = 1'b0; ftick();
    pix(100, 50, 1'b1); step(); pix(0, 0, 1'b0);
    chk("t3_idle", 32'(bus.rom_addr), 0);

    // 4: edges
    pix(105, 50, 1'b1); step();
    chk("t4_addr5", 32'(bus.rom_addr), 5);
    boy_x = 10'd1010; pix(2, 50, 1'b1); step();
    chk("t4_nowrap_addr", 32'(bus.rom_addr), 5);
    boy_x = 10'd100; pix(99, 51, 1'b1); step();
    chk("t4_left_addr", 32'(bus.rom_addr), 5);
    pix(132, 51, 1'b1); step();
    chk("t4_right_addr", 32'(bus.rom_addr), 5);
    chk("t4_nowrap_on", 32'(boy_on), 0);
    pix(0, 0, 1'b0); step();
    chk("t4_left_on", 32'(boy_on), 0);
    step();
    chk("t4_right_on", 32'(boy_on), 0);

    // 5: transparent and pix_en gating
    force_transp = 1'b1;
    pix(100, 50, 1'b1); step();
    pix(0, 0, 1'b0); step(); step();
    chk("t5_transp_on", 32'(boy_on), 0);
    chk("t5_transp_pal", 32'(pal_index), 0);
    force_transp = 1'b0;
    pix(110, 50, 1'b0); step();
    chk("t5_pixen_addr", 32'(bus.rom_addr), 0);
    step(); step();
    chk("t5_pixen_on", 32'(boy_on), 0);

    // 6: mid-row reset
    moving = 1'b1; ftick();
    for (int i = 0; i < 8; i++) ftick();
    pix(100, 50, 1'b1); step(); step(); step();
    chk("t6_pre_addr", 32'(bus.rom_addr), 1024);
    chk("t6_pre_on", 32'(boy_on), 1);
    facing_left = 1'b0;
    reset_n = 1'b0; #1;
    chk("t6_rst_on", 32'(boy_on), 0);
    chk("t6_rst_addr", 32'(bus.rom_addr), 0);
    pix(0, 0, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    chk("t6_nostale", 32'(boy_on), 0);
    pix(100, 50, 1'b1); step();
    chk("t6_idle_addr", 32'(bus.rom_addr), 0);
    pix(0, 0, 1'b0); step();
    chk("t6_lat2", 32'(boy_on), 0);
    step();
    chk("t6_lat3_on", 32'(boy_on), 1);
    chk("t6_lat3_pal", 32'(pal_index), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
